// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine
//   SPI-mode SD command engine. Accepts one command (index, argument,
//   response length) over a valid/ready handshake, builds the 6-byte frame
//   (optionally with an internally generated CRC7), has the byte-oriented
//   SPI master send it, polls single bytes until an R1 token (bit7 = 0)
//   arrives or MAX_POLL polls have been spent, then reads 0-4 trailing
//   response bytes (R3/R7).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_index/arg/crc     command fields; cmd_crc used only when GEN_CRC = 0
//   resp_len              trailing bytes after R1 (5-7 behave as 4)
//   keep_cs               leave spi_ss low once the command completes
//   resp_valid            one-cycle completion pulse
//   resp_r1/data/timeout  response; held until the next accepted command
//   spi_size/op/start/ss  registered controls towards the SPI master
//   spi_data_in           frame byte at spi_address (combinational)
//   spi_address/data_out/rx_valid/done   feedback from the SPI master
module sd_cmd_engine #(
  parameter int MEMORY_SIZE_IN_BYTES = 64,
  parameter int MAX_POLL             = 8,
  parameter int GEN_CRC              = 1,
  localparam int AW                  = $clog2(MEMORY_SIZE_IN_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [5:0]    cmd_index,
  input  logic [31:0]   cmd_arg,
  input  logic [6:0]    cmd_crc,
  input  logic [2:0]    resp_len,
  input  logic          keep_cs,
  output logic          resp_valid,
  output logic [7:0]    resp_r1,
  output logic [31:0]   resp_data,
  output logic          resp_timeout,
  output logic [AW-1:0] spi_size,
  output logic          spi_op,
  output logic [7:0]    spi_data_in,
  input  logic [2:0]    spi_address,
  input  logic [7:0]    spi_data_out,
  input  logic          spi_rx_valid,
  output logic          spi_start,
  output logic          spi_ss,
  input  logic          spi_done
);

  localparam int PW = $clog2(MAX_POLL + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_TX   = 3'd1,
    S_START     = 3'd2,
    S_WAIT      = 3'd3,
    S_LOAD_POLL = 3'd4,
    S_LOAD_DATA = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  // Which transfer the shared START/WAIT pair is currently serving.
  typedef enum logic [1:0] {
    PH_TX   = 2'd0,
    PH_POLL = 2'd1,
    PH_DATA = 2'd2
  } phase_t;

  // CRC7 (x^7 + x^3 + 1, init 0) over the first five frame bytes, MSB first.
  function automatic logic [6:0] crc7_calc(input logic [39:0] msg);
    logic [6:0] crc;
    logic       fb;
    crc = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb  = msg[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  state_t         state_q, state_d;
  state_t         ret_q, ret_d;
  phase_t         phase_q, phase_d;
  logic [5:0]     idx_q, idx_d;
  logic [31:0]    arg_q, arg_d;
  logic [6:0]     crc_q, crc_d;
  logic [2:0]     len_q, len_d;
  logic           keep_q, keep_d;
  logic [PW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [7:0]     poll_byte_q, poll_byte_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           resp_valid_q, resp_valid_d;
  logic [7:0]     resp_r1_q, resp_r1_d;
  logic [31:0]    resp_data_q, resp_data_d;
  logic           resp_timeout_q, resp_timeout_d;
  logic [AW-1:0]  spi_size_q, spi_size_d;
  logic           spi_op_q, spi_op_d;
  logic           spi_start_q, spi_start_d;
  logic           spi_ss_q, spi_ss_d;
  logic [7:0]     poll_byte_now;

  // A byte arriving together with spi_done must take part in the decision.
  assign poll_byte_now = spi_rx_valid ? spi_data_out : poll_byte_q;

  assign cmd_ready    = cmd_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_r1      = resp_r1_q;
  assign resp_data    = resp_data_q;
  assign resp_timeout = resp_timeout_q;
  assign spi_size     = spi_size_q;
  assign spi_op       = spi_op_q;
  assign spi_start    = spi_start_q;
  assign spi_ss       = spi_ss_q;

  // Frame byte selection for the SPI master; out-of-frame addresses read as idle 0xFF.
  always_comb begin
    case (spi_address)
      3'd0:    spi_data_in = {2'b01, idx_q};
      3'd1:    spi_data_in = arg_q[31:24];
      3'd2:    spi_data_in = arg_q[23:16];
      3'd3:    spi_data_in = arg_q[15:8];
      3'd4:    spi_data_in = arg_q[7:0];
      3'd5:    spi_data_in = {crc_q, 1'b1};
      default: spi_data_in = 8'hFF;
    endcase
  end

  // Next-state and next-output logic for the command sequencer.
  always_comb begin
    state_d        = state_q;
    ret_d          = ret_q;
    phase_d        = phase_q;
    idx_d          = idx_q;
    arg_d          = arg_q;
    crc_d          = crc_q;
    len_d          = len_q;
    keep_d         = keep_q;
    poll_cnt_d     = poll_cnt_q;
    poll_byte_d    = poll_byte_q;
    resp_valid_d   = 1'b0;
    resp_r1_d      = resp_r1_q;
    resp_data_d    = resp_data_q;
    resp_timeout_d = resp_timeout_q;
    spi_size_d     = spi_size_q;
    spi_op_d       = spi_op_q;
    spi_start_d    = 1'b0;
    spi_ss_d       = spi_ss_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          idx_d          = cmd_index;
          arg_d          = cmd_arg;
          crc_d          = (GEN_CRC != 0) ? crc7_calc({2'b01, cmd_index, cmd_arg}) : cmd_crc;
          len_d          = (resp_len > 3'd4) ? 3'd4 : resp_len;
          keep_d         = keep_cs;
          resp_data_d    = 32'h0000_0000;
          resp_timeout_d = 1'b0;
          poll_cnt_d     = '0;
          state_d        = S_LOAD_TX;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD_TX: begin
        spi_size_d = AW'(5);
        spi_op_d   = 1'b1;
        spi_ss_d   = 1'b0;
        phase_d    = PH_TX;
        ret_d      = S_LOAD_POLL;
        state_d    = S_START;
      end

      S_START: begin
        spi_start_d = 1'b1;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        if (spi_rx_valid) begin
          case (phase_q)
            PH_POLL: poll_byte_d = spi_data_out;
            PH_DATA: resp_data_d = {resp_data_q[23:0], spi_data_out};
            default: poll_byte_d = poll_byte_q;
          endcase
        end else begin
          poll_byte_d = poll_byte_q;
        end

        if (spi_done) begin
          if (phase_q == PH_POLL) begin
            // Poll transfers decide the follow-up from the received byte.
            if (!poll_byte_now[7]) begin
              resp_r1_d = poll_byte_now;
              state_d   = (len_q == 3'd0) ? S_FINISH : S_LOAD_DATA;
            end else if (poll_cnt_q == PW'(MAX_POLL)) begin
              resp_r1_d      = 8'hFF;
              resp_timeout_d = 1'b1;
              state_d        = S_FINISH;
            end else begin
              state_d = S_LOAD_POLL;
            end
          end else begin
            state_d = ret_q;
          end

          // Completion is flagged on entry to FINISH so it is visible right after spi_done.
          if (state_d == S_FINISH) begin
            resp_valid_d = 1'b1;
            spi_ss_d     = keep_q ? 1'b0 : 1'b1;
          end else begin
            spi_ss_d = spi_ss_q;
          end
        end else begin
          state_d = S_WAIT;
        end
      end

      S_LOAD_POLL: begin
        spi_size_d  = '0;
        spi_op_d    = 1'b0;
        phase_d     = PH_POLL;
        ret_d       = S_LOAD_POLL;
        poll_byte_d = 8'hFF;
        if (poll_cnt_q != PW'(MAX_POLL)) begin
          poll_cnt_d = poll_cnt_q + PW'(1);
        end else begin
          poll_cnt_d = poll_cnt_q;
        end
        state_d = S_START;
      end

      S_LOAD_DATA: begin
        spi_size_d = AW'(len_q - 3'd1);
        spi_op_d   = 1'b0;
        phase_d    = PH_DATA;
        ret_d      = S_FINISH;
        state_d    = S_START;
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered ready: high exactly while the sequencer sits in IDLE.
    cmd_ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ret_q          <= S_IDLE;
      phase_q        <= PH_TX;
      idx_q          <= 6'd0;
      arg_q          <= 32'h0000_0000;
      crc_q          <= 7'h00;
      len_q          <= 3'd0;
      keep_q         <= 1'b0;
      poll_cnt_q     <= '0;
      poll_byte_q    <= 8'hFF;
      cmd_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_r1_q      <= 8'hFF;
      resp_data_q    <= 32'h0000_0000;
      resp_timeout_q <= 1'b0;
      spi_size_q     <= '0;
      spi_op_q       <= 1'b0;
      spi_start_q    <= 1'b0;
      spi_ss_q       <= 1'b1;
    end else begin
      state_q        <= state_d;
      ret_q          <= ret_d;
      phase_q        <= phase_d;
      idx_q          <= idx_d;
      arg_q          <= arg_d;
      crc_q          <= crc_d;
      len_q          <= len_d;
      keep_q         <= keep_d;
      poll_cnt_q     <= poll_cnt_d;
      poll_byte_q    <= poll_byte_d;
      cmd_ready_q    <= cmd_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_r1_q      <= resp_r1_d;
      resp_data_q    <= resp_data_d;
      resp_timeout_q <= resp_timeout_d;
      spi_size_q     <= spi_size_d;
      spi_op_q       <= spi_op_d;
      spi_start_q    <= spi_start_d;
      spi_ss_q       <= spi_ss_d;
    end
  end

endmodule
